// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous memory between instruction fetch (IF) and data memory (DM).
// DM wins by default; a saturating starvation counter lets IF through after STARVE_LIMIT lost slots.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned LAT_W = $clog2(MEM_LATENCY + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_e;

  state_e           state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [STV_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             kill_q, kill_d;
  logic             dm_we_q, dm_we_d;

  logic resp, slot, starved, dm_win, if_win, kill_eff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      kill_q       <= 1'b0;
      dm_we_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      kill_q       <= kill_d;
      dm_we_q      <= dm_we_d;
    end
  end

  // Arbitration, next-state and starvation bookkeeping.
  always_comb begin
    resp     = (state_q != IDLE) && (lat_cnt_q == LAT_W'(MEM_LATENCY));
    slot     = (state_q == IDLE) || resp;
    starved  = (starve_cnt_q == STV_W'(STARVE_LIMIT));
    dm_win   = slot && dm_req && !(starved && if_req && !flush);
    if_win   = slot && if_req && !flush && !dm_win;
    kill_eff = kill_q || flush;

    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    kill_d       = kill_q;
    dm_we_d      = dm_we_q;

    if (if_win) begin
      state_d   = BUSY_IF;
      lat_cnt_d = LAT_W'(1);
      kill_d    = 1'b0;
    end else if (dm_win) begin
      state_d   = BUSY_DM;
      lat_cnt_d = LAT_W'(1);
      kill_d    = 1'b0;
      dm_we_d   = dm_we;
    end else if (slot) begin
      state_d   = IDLE;
      lat_cnt_d = '0;
      kill_d    = 1'b0;
    end else begin
      lat_cnt_d = lat_cnt_q + LAT_W'(1);
      if (state_q == BUSY_IF) kill_d = kill_eff;
    end

    // Slots where IF is blocked only by flush leave the counter unchanged.
    if (slot) begin
      if (if_win || !if_req) starve_cnt_d = '0;
      else if (dm_win && !starved) starve_cnt_d = starve_cnt_q + STV_W'(1);
    end
  end

  // Port outputs; forced low while reset is asserted.
  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    if_rdata  = '0;
    dm_rdata  = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset_n) begin
      if_gnt = if_win;
      dm_gnt = dm_win;
      mem_en = if_win || dm_win;
      if (if_win) begin
        mem_addr = if_addr;
      end else if (dm_win) begin
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end
      if (resp && (state_q == BUSY_IF) && !kill_eff) begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
      if (resp && (state_q == BUSY_DM)) begin
        dm_rvalid = 1'b1;
        dm_rdata  = dm_we_q ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LATENCY=1 and one with MEM_LATENCY=3.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush, if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;

  logic        if_gnt_1, if_rvalid_1, dm_gnt_1, dm_rvalid_1, mem_en_1, mem_we_1;
  logic [31:0] if_rdata_1, dm_rdata_1, mem_addr_1, mem_wdata_1;
  logic        if_gnt_3, if_rvalid_3, dm_gnt_3, dm_rvalid_3, mem_en_3, mem_we_3;
  logic [31:0] if_rdata_3, dm_rdata_3, mem_addr_3, mem_wdata_3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_1), .if_rvalid(if_rvalid_1), .if_rdata(if_rdata_1),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt_1), .dm_rvalid(dm_rvalid_1), .dm_rdata(dm_rdata_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u_lat3 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_3), .if_rvalid(if_rvalid_3), .if_rdata(if_rdata_3),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt_3), .dm_rvalid(dm_rvalid_3), .dm_rdata(dm_rdata_3),
    .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle: inputs change 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    flush = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) next_cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    do_reset();

    // Reset state: idle outputs.
    settle();
    chk("idle_if_gnt", 32'(if_gnt_1), 32'd0);
    chk("idle_mem_en", 32'(mem_en_1), 32'd0);
    chk("idle_mem_addr", mem_addr_1, 32'h0);

    // Latency: IF fetch of 0x100 answered one cycle later.
    next_cycle();
    if_req = 1'b1; if_addr = 32'h100;
    settle();
    chk("lat_if_gnt", 32'(if_gnt_1), 32'd1);
    chk("lat_mem_en", 32'(mem_en_1), 32'd1);
    chk("lat_mem_addr", mem_addr_1, 32'h100);
    chk("lat_mem_we", 32'(mem_we_1), 32'd0);
    next_cycle();
    if_req = 1'b0; mem_rdata = 32'hDEADBEEF;
    settle();
    chk("lat_if_rvalid", 32'(if_rvalid_1), 32'd1);
    chk("lat_if_rdata", if_rdata_1, 32'hDEADBEEF);
    chk("lat_dm_rvalid", 32'(dm_rvalid_1), 32'd0);
    next_cycle();
    settle();
    chk("lat_rvalid_drop", 32'(if_rvalid_1), 32'd0);
    chk("lat_rdata_zero", if_rdata_1, 32'h0);

    // Priority: DM wins, IF granted in the DM response cycle.
    do_reset();
    next_cycle();
    if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1; dm_addr = 32'h300;
    settle();
    chk("pri_dm_gnt", 32'(dm_gnt_1), 32'd1);
    chk("pri_if_gnt0", 32'(if_gnt_1), 32'd0);
    chk("pri_mem_addr_dm", mem_addr_1, 32'h300);
    next_cycle();
    dm_req = 1'b0; mem_rdata = 32'h0000A5A5;
    settle();
    chk("pri_dm_rvalid", 32'(dm_rvalid_1), 32'd1);
    chk("pri_dm_rdata", dm_rdata_1, 32'h0000A5A5);
    chk("pri_if_gnt1", 32'(if_gnt_1), 32'd1);
    chk("pri_mem_addr_if", mem_addr_1, 32'h200);
    next_cycle();
    if_req = 1'b0; mem_rdata = 32'h0BADF00D;
    settle();
    chk("pri_if_rvalid", 32'(if_rvalid_1), 32'd1);
    chk("pri_if_rdata", if_rdata_1, 32'h0BADF00D);
    chk("pri_dm_rvalid0", 32'(dm_rvalid_1), 32'd0);

    // Starvation: DM at cycles 0-3, IF at 4, DM at 5.
    do_reset();
    next_cycle();
    if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h400; dm_addr = 32'h500;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk($sformatf("stv_if_gnt_c%0d", i), 32'(if_gnt_1), (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("stv_dm_gnt_c%0d", i), 32'(dm_gnt_1), (i == 4) ? 32'd0 : 32'd1);
      next_cycle();
    end
    if_req = 1'b0; dm_req = 1'b0;

    // Flush: killed fetch, then a fresh fetch of 0x104 valid 3 cycles later.
    do_reset();
    next_cycle();
    if_req = 1'b1; if_addr = 32'h100;
    settle();
    chk("fl_if_gnt_c0", 32'(if_gnt_3), 32'd1);
    next_cycle();
    if_req = 1'b0;
    settle();
    chk("fl_mem_en_c1", 32'(mem_en_3), 32'd0);
    next_cycle();
    flush = 1'b1;
    settle();
    chk("fl_rvalid_c2", 32'(if_rvalid_3), 32'd0);
    next_cycle();
    flush = 1'b0; if_req = 1'b1; if_addr = 32'h104; mem_rdata = 32'h11111111;
    settle();
    chk("fl_rvalid_c3", 32'(if_rvalid_3), 32'd0);
    chk("fl_rdata_c3", if_rdata_3, 32'h0);
    chk("fl_if_gnt_c3", 32'(if_gnt_3), 32'd1);
    chk("fl_mem_addr_c3", mem_addr_3, 32'h104);
    next_cycle();
    if_req = 1'b0;
    settle();
    chk("fl_rvalid_c4", 32'(if_rvalid_3), 32'd0);
    next_cycle();
    next_cycle();
    mem_rdata = 32'h22222222;
    settle();
    chk("fl_rvalid_c6", 32'(if_rvalid_3), 32'd1);
    chk("fl_rdata_c6", if_rdata_3, 32'h22222222);
    // Flush blocks IF but never DM.
    next_cycle();
    flush = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_addr = 32'h600;
    settle();
    chk("fl_dm_gnt", 32'(dm_gnt_3), 32'd1);
    chk("fl_if_blocked", 32'(if_gnt_3), 32'd0);
    next_cycle();
    clear_inputs();

    // Store: write command then zero-data completion.
    do_reset();
    next_cycle();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'h12345678;
    settle();
    chk("st_dm_gnt", 32'(dm_gnt_1), 32'd1);
    chk("st_mem_we", 32'(mem_we_1), 32'd1);
    chk("st_mem_addr", mem_addr_1, 32'h2000);
    chk("st_mem_wdata", mem_wdata_1, 32'h12345678);
    next_cycle();
    dm_req = 1'b0; dm_we = 1'b0; mem_rdata = 32'hFFFFFFFF;
    settle();
    chk("st_dm_rvalid", 32'(dm_rvalid_1), 32'd1);
    chk("st_dm_rdata", dm_rdata_1, 32'h0);

    // Reset mid-access: outputs drop immediately, no stale response afterwards.
    do_reset();
    next_cycle();
    if_req = 1'b1; if_addr = 32'h700;
    settle();
    chk("rst_if_gnt_c0", 32'(if_gnt_3), 32'd1);
    next_cycle();
    if_req = 1'b0;
    next_cycle();
    reset_n = 1'b0; if_req = 1'b1; mem_rdata = 32'h33333333;
    #1;
    chk("rst_if_gnt", 32'(if_gnt_3), 32'd0);
    chk("rst_mem_en", 32'(mem_en_3), 32'd0);
    chk("rst_mem_addr", mem_addr_3, 32'h0);
    chk("rst_if_rvalid", 32'(if_rvalid_3), 32'd0);
    chk("rst_if_gnt_lat1", 32'(if_gnt_1), 32'd0);
    next_cycle();
    if_req = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("rst_no_rvalid_%0d", i), 32'(if_rvalid_3 | dm_rvalid_3), 32'd0);
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
